// File: rtl/prt_lb_mux_tmo_pkg.sv
// rtl/prt_lb_mux_tmo_pkg.sv - shared types and helpers for the local-bus mux
package prt_lb_mux_pkg;

    // Read-tracking FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        ERR_RSP = 2'd2
    } state_t;

    // Sticky status flags plus saturating event counter
    typedef struct packed {
        logic       tmo;
        logic       dec;
        logic       prot;
        logic [7:0] cnt;
    } sta_t;

    localparam int         TMO_W   = 16;
    localparam logic [7:0] CNT_MAX = 8'hFF;

    // Width of the port-select field for a given port count
    function automatic int sel_width(input int ports);
        return (ports < 2) ? 1 : $clog2(ports);
    endfunction

endpackage

// File: rtl/prt_lb_mux_tmo_if.sv
// rtl/prt_lb_mux_tmo_if.sv - upstream, downstream and status signal bundle
interface prt_lb_mux_tmo_if #(
    parameter int P_PORTS   = 16,
    parameter int P_UP_ADR  = 22,
    parameter int P_DWN_ADR = 16,
    parameter int P_DAT     = 32
);
    logic [P_UP_ADR-1:0]        UP_ADR_IN;
    logic                       UP_WR_IN;
    logic                       UP_RD_IN;
    logic [P_DAT-1:0]           UP_DIN_IN;
    logic [P_DAT-1:0]           UP_DOUT_OUT;
    logic                       UP_VLD_OUT;
    logic [P_DWN_ADR-1:0]       DWN_ADR_OUT;
    logic [P_DAT-1:0]           DWN_DIN_OUT;
    logic [P_PORTS-1:0]         DWN_WR_OUT;
    logic [P_PORTS-1:0]         DWN_RD_OUT;
    logic [P_PORTS*P_DAT-1:0]   DWN_DOUT_IN;
    logic [P_PORTS-1:0]         DWN_VLD_IN;
    logic                       STA_CLR_IN;
    logic                       STA_TMO_OUT;
    logic                       STA_DEC_OUT;
    logic                       STA_PROT_OUT;
    logic [7:0]                 STA_ERR_CNT_OUT;

    // Mux side
    modport slave (
        input  UP_ADR_IN, UP_WR_IN, UP_RD_IN, UP_DIN_IN,
        output UP_DOUT_OUT, UP_VLD_OUT,
        output DWN_ADR_OUT, DWN_DIN_OUT, DWN_WR_OUT, DWN_RD_OUT,
        input  DWN_DOUT_IN, DWN_VLD_IN,
        input  STA_CLR_IN,
        output STA_TMO_OUT, STA_DEC_OUT, STA_PROT_OUT, STA_ERR_CNT_OUT
    );

    // CPU / peripheral side
    modport master (
        output UP_ADR_IN, UP_WR_IN, UP_RD_IN, UP_DIN_IN,
        input  UP_DOUT_OUT, UP_VLD_OUT,
        input  DWN_ADR_OUT, DWN_DIN_OUT, DWN_WR_OUT, DWN_RD_OUT,
        output DWN_DOUT_IN, DWN_VLD_IN,
        output STA_CLR_IN,
        input  STA_TMO_OUT, STA_DEC_OUT, STA_PROT_OUT, STA_ERR_CNT_OUT
    );
endinterface

// File: rtl/prt_lb_mux_tmo_sta.sv
// rtl/prt_lb_mux_tmo_sta.sv - sticky error flags and saturating event counter
module prt_lb_mux_tmo_sta
    import prt_lb_mux_pkg::*;
(
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic tmo_ev_i,
    input  logic dec_ev_i,
    input  logic prot_ev_i,
    output sta_t sta_o
);
    sta_t sta_q;
    sta_t sta_d;

    // Clear wins over events; simultaneous events count once
    always_comb begin
        sta_d = sta_q;
        if (clr_i) begin
            sta_d = '0;
        end else begin
            if (tmo_ev_i)  sta_d.tmo  = 1'b1;
            if (dec_ev_i)  sta_d.dec  = 1'b1;
            if (prot_ev_i) sta_d.prot = 1'b1;
            if ((tmo_ev_i || dec_ev_i || prot_ev_i) && (sta_q.cnt != CNT_MAX))
                sta_d.cnt = sta_q.cnt + 8'd1;
        end
    end

    // Status register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) sta_q <= '0;
        else          sta_q <= sta_d;
    end

    assign sta_o = sta_q;

endmodule

// File: rtl/prt_lb_mux_tmo.sv
// rtl/prt_lb_mux_tmo.sv - address-decoding local-bus mux with read timeout
module prt_lb_mux_tmo
    import prt_lb_mux_pkg::*;
#(
    parameter int               P_PORTS   = 16,
    parameter int               P_UP_ADR  = 22,
    parameter int               P_DWN_ADR = 16,
    parameter int               P_DAT     = 32,
    parameter int               P_TMO     = 255,
    parameter logic [P_DAT-1:0] P_ERR_DAT = 32'hDEAD_BEEF
)(
    input logic              CLK_IN,
    input logic              RST_IN,
    prt_lb_mux_tmo_if.slave  bus
);
    localparam int               SEL_W   = sel_width(P_PORTS);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(P_TMO);

    logic [1:0]           rst_sync_q;
    logic                 rst_n;

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic [P_PORTS-1:0]   dwn_wr_q, dwn_wr_d;
    logic [P_PORTS-1:0]   dwn_rd_q, dwn_rd_d;
    logic [P_DWN_ADR-1:0] dwn_adr_q, dwn_adr_d;
    logic [P_DAT-1:0]     dwn_din_q, dwn_din_d;
    logic                 up_vld_q, up_vld_d;
    logic [P_DAT-1:0]     up_dout_q, up_dout_d;

    logic [SEL_W-1:0]     sel;
    logic [31:0]          sel_ext;
    logic                 dec_ok;
    logic [P_PORTS-1:0]   sel_oh;
    logic                 rd_vld;
    logic [P_DAT-1:0]     rd_dat;
    logic                 tmo_ev, dec_ev, prot_ev;
    sta_t                 sta;
    logic                 unused_adr;

    // Assert asynchronously, release two clocks after RST_IN rises
    always_ff @(posedge CLK_IN or negedge RST_IN) begin
        if (!RST_IN) rst_sync_q <= 2'b00;
        else         rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    // Port select lives just above the downstream address field
    assign sel        = bus.UP_ADR_IN[P_DWN_ADR +: SEL_W];
    assign sel_ext    = 32'(sel);
    assign dec_ok     = (sel_ext < P_PORTS);
    assign sel_oh     = {{(P_PORTS-1){1'b0}}, 1'b1} << sel;
    assign unused_adr = ^bus.UP_ADR_IN;

    // Response mux for the port the pending read went to
    always_comb begin
        rd_vld = 1'b0;
        rd_dat = '0;
        for (int i = 0; i < P_PORTS; i++) begin
            if (sel_q == SEL_W'(i)) begin
                rd_vld = bus.DWN_VLD_IN[i];
                rd_dat = bus.DWN_DOUT_IN[i*P_DAT +: P_DAT];
            end
        end
    end

    // Decode, read tracking and error detection
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        tmo_d     = tmo_q;
        dwn_wr_d  = '0;
        dwn_rd_d  = '0;
        dwn_adr_d = dwn_adr_q;
        dwn_din_d = dwn_din_q;
        up_vld_d  = 1'b0;
        up_dout_d = up_dout_q;
        tmo_ev    = 1'b0;
        dec_ev    = 1'b0;
        prot_ev   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.UP_WR_IN) begin
                    if (dec_ok) begin
                        dwn_wr_d  = sel_oh;
                        dwn_adr_d = bus.UP_ADR_IN[P_DWN_ADR-1:0];
                        dwn_din_d = bus.UP_DIN_IN;
                    end else begin
                        dec_ev = 1'b1;
                    end
                    if (bus.UP_RD_IN) prot_ev = 1'b1;
                end else if (bus.UP_RD_IN) begin
                    if (dec_ok) begin
                        dwn_rd_d  = sel_oh;
                        dwn_adr_d = bus.UP_ADR_IN[P_DWN_ADR-1:0];
                        sel_d     = sel;
                        tmo_d     = TMO_W'(1);
                        state_d   = RD_WAIT;
                    end else begin
                        dec_ev    = 1'b1;
                        up_vld_d  = 1'b1;
                        up_dout_d = P_ERR_DAT;
                        state_d   = ERR_RSP;
                    end
                end
            end
            RD_WAIT: begin
                if (bus.UP_WR_IN || bus.UP_RD_IN) prot_ev = 1'b1;
                if (rd_vld) begin
                    up_vld_d  = 1'b1;
                    up_dout_d = rd_dat;
                    state_d   = IDLE;
                end else if (tmo_q == TMO_MAX) begin
                    up_vld_d  = 1'b1;
                    up_dout_d = P_ERR_DAT;
                    tmo_ev    = 1'b1;
                    state_d   = IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ERR_RSP: begin
                if (bus.UP_WR_IN || bus.UP_RD_IN) prot_ev = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered bus outputs
    always_ff @(posedge CLK_IN or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            tmo_q     <= '0;
            dwn_wr_q  <= '0;
            dwn_rd_q  <= '0;
            dwn_adr_q <= '0;
            dwn_din_q <= '0;
            up_vld_q  <= 1'b0;
            up_dout_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            tmo_q     <= tmo_d;
            dwn_wr_q  <= dwn_wr_d;
            dwn_rd_q  <= dwn_rd_d;
            dwn_adr_q <= dwn_adr_d;
            dwn_din_q <= dwn_din_d;
            up_vld_q  <= up_vld_d;
            up_dout_q <= up_dout_d;
        end
    end

    prt_lb_mux_tmo_sta u_sta (
        .clk_i     (CLK_IN),
        .rst_n_i   (rst_n),
        .clr_i     (bus.STA_CLR_IN),
        .tmo_ev_i  (tmo_ev),
        .dec_ev_i  (dec_ev),
        .prot_ev_i (prot_ev),
        .sta_o     (sta)
    );

    assign bus.UP_VLD_OUT      = up_vld_q;
    assign bus.UP_DOUT_OUT     = up_dout_q;
    assign bus.DWN_ADR_OUT     = dwn_adr_q;
    assign bus.DWN_DIN_OUT     = dwn_din_q;
    assign bus.DWN_WR_OUT      = dwn_wr_q;
    assign bus.DWN_RD_OUT      = dwn_rd_q;
    assign bus.STA_TMO_OUT     = sta.tmo;
    assign bus.STA_DEC_OUT     = sta.dec;
    assign bus.STA_PROT_OUT    = sta.prot;
    assign bus.STA_ERR_CNT_OUT = sta.cnt;

endmodule

// File: tb/tb_prt_lb_mux_tmo.sv
// tb/tb_prt_lb_mux_tmo.sv - directed self-checking bench for prt_lb_mux_tmo
module tb_prt_lb_mux_tmo;
    logic clk;
    logic rst_n;
    int   n_run;
    int   n_fail;

    prt_lb_mux_tmo_if #(.P_PORTS(16), .P_UP_ADR(22), .P_DWN_ADR(16), .P_DAT(32)) bus16 ();
    prt_lb_mux_tmo_if #(.P_PORTS(11), .P_UP_ADR(22), .P_DWN_ADR(16), .P_DAT(32)) bus11 ();

    prt_lb_mux_tmo #(.P_PORTS(16), .P_UP_ADR(22), .P_DWN_ADR(16), .P_DAT(32),
                     .P_TMO(10), .P_ERR_DAT(32'hDEAD_BEEF)) dut16 (
        .CLK_IN (clk),
        .RST_IN (rst_n),
        .bus    (bus16)
    );

    prt_lb_mux_tmo #(.P_PORTS(11), .P_UP_ADR(22), .P_DWN_ADR(16), .P_DAT(32),
                     .P_TMO(10), .P_ERR_DAT(32'hDEAD_BEEF)) dut11 (
        .CLK_IN (clk),
        .RST_IN (rst_n),
        .bus    (bus11)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic clr_all();
        @(negedge clk);
        bus16.STA_CLR_IN = 1'b1;
        bus11.STA_CLR_IN = 1'b1;
        @(negedge clk);
        bus16.STA_CLR_IN = 1'b0;
        bus11.STA_CLR_IN = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_run++; if (bus16.DWN_WR_OUT !== 16'h0 || bus16.DWN_RD_OUT !== 16'h0) begin n_fail++; $display("FAIL reset_strobes: got %h/%h want 0/0", bus16.DWN_WR_OUT, bus16.DWN_RD_OUT); end
        n_run++; if (bus16.UP_VLD_OUT !== 1'b0 || bus16.UP_DOUT_OUT !== 32'h0) begin n_fail++; $display("FAIL reset_up: got %b/%h want 0/0", bus16.UP_VLD_OUT, bus16.UP_DOUT_OUT); end
        n_run++; if ({bus16.STA_TMO_OUT, bus16.STA_DEC_OUT, bus16.STA_PROT_OUT, bus16.STA_ERR_CNT_OUT} !== 11'h0) begin n_fail++; $display("FAIL reset_sta: got %b%b%b cnt %0d want 000 cnt 0", bus16.STA_TMO_OUT, bus16.STA_DEC_OUT, bus16.STA_PROT_OUT, bus16.STA_ERR_CNT_OUT); end
    endtask

    task automatic test_write();
        @(negedge clk);
        bus16.UP_ADR_IN = 22'h3_0004;
        bus16.UP_DIN_IN = 32'hA5A5_0001;
        bus16.UP_WR_IN  = 1'b1;
        @(negedge clk);
        bus16.UP_WR_IN  = 1'b0;
        n_run++; if (bus16.DWN_WR_OUT !== 16'h0008) begin n_fail++; $display("FAIL wr_strobe: got %h want 0008", bus16.DWN_WR_OUT); end
        n_run++; if (bus16.DWN_ADR_OUT !== 16'h0004 || bus16.DWN_DIN_OUT !== 32'hA5A5_0001) begin n_fail++; $display("FAIL wr_adr_dat: got %h/%h want 0004/a5a50001", bus16.DWN_ADR_OUT, bus16.DWN_DIN_OUT); end
        n_run++; if (bus16.UP_VLD_OUT !== 1'b0 || bus16.DWN_RD_OUT !== 16'h0) begin n_fail++; $display("FAIL wr_no_rsp: got vld %b rd %h want 0/0", bus16.UP_VLD_OUT, bus16.DWN_RD_OUT); end
        @(negedge clk);
        n_run++; if (bus16.DWN_WR_OUT !== 16'h0 || bus16.UP_VLD_OUT !== 1'b0) begin n_fail++; $display("FAIL wr_one_cycle: got %h vld %b want 0/0", bus16.DWN_WR_OUT, bus16.UP_VLD_OUT); end
    endtask

    task automatic test_read_zero_wait();
        @(negedge clk);
        bus16.UP_ADR_IN = 22'h5_0010;
        bus16.UP_RD_IN  = 1'b1;
        @(negedge clk);
        bus16.UP_RD_IN  = 1'b0;
        n_run++; if (bus16.DWN_RD_OUT !== 16'h0020 || bus16.DWN_ADR_OUT !== 16'h0010) begin n_fail++; $display("FAIL rd_strobe: got %h adr %h want 0020/0010", bus16.DWN_RD_OUT, bus16.DWN_ADR_OUT); end
        n_run++; if (bus16.UP_VLD_OUT !== 1'b0) begin n_fail++; $display("FAIL rd_early_vld: got %b want 0", bus16.UP_VLD_OUT); end
        bus16.DWN_VLD_IN[5] = 1'b1;
        bus16.DWN_DOUT_IN[5*32 +: 32] = 32'h1234_5678;
        @(negedge clk);
        bus16.DWN_VLD_IN[5] = 1'b0;
        n_run++; if (bus16.UP_VLD_OUT !== 1'b1 || bus16.UP_DOUT_OUT !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_data: got %b/%h want 1/12345678", bus16.UP_VLD_OUT, bus16.UP_DOUT_OUT); end
        n_run++; if ({bus16.STA_TMO_OUT, bus16.STA_DEC_OUT, bus16.STA_PROT_OUT, bus16.STA_ERR_CNT_OUT} !== 11'h0) begin n_fail++; $display("FAIL rd_sta: got cnt %0d want clean status", bus16.STA_ERR_CNT_OUT); end
        @(negedge clk);
        n_run++; if (bus16.UP_VLD_OUT !== 1'b0 || bus16.UP_DOUT_OUT !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_hold: got %b/%h want 0/12345678", bus16.UP_VLD_OUT, bus16.UP_DOUT_OUT); end
    endtask

    task automatic test_timeout();
        bit early;
        early = 1'b0;
        @(negedge clk);
        bus16.UP_ADR_IN = 22'h7_0000;
        bus16.UP_RD_IN  = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            bus16.UP_RD_IN = 1'b0;
            if (bus16.UP_VLD_OUT !== 1'b0) early = 1'b1;
        end
        n_run++; if (early) begin n_fail++; $display("FAIL tmo_early: got vld before cycle 11 want none"); end
        @(negedge clk);
        n_run++; if (bus16.UP_VLD_OUT !== 1'b1 || bus16.UP_DOUT_OUT !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL tmo_rsp: got %b/%h want 1/deadbeef", bus16.UP_VLD_OUT, bus16.UP_DOUT_OUT); end
        n_run++; if (bus16.STA_TMO_OUT !== 1'b1 || bus16.STA_ERR_CNT_OUT !== 8'd1) begin n_fail++; $display("FAIL tmo_sta: got %b cnt %0d want 1 cnt 1", bus16.STA_TMO_OUT, bus16.STA_ERR_CNT_OUT); end
        @(negedge clk);
        bus16.DWN_VLD_IN[7] = 1'b1;
        bus16.DWN_DOUT_IN[7*32 +: 32] = 32'h7777_7777;
        @(negedge clk);
        bus16.DWN_VLD_IN[7] = 1'b0;
        @(negedge clk);
        n_run++; if (bus16.UP_VLD_OUT !== 1'b0 || bus16.UP_DOUT_OUT !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL tmo_late: got %b/%h want 0/deadbeef", bus16.UP_VLD_OUT, bus16.UP_DOUT_OUT); end
    endtask

    task automatic test_vld_at_tmo();
        clr_all();
        @(negedge clk);
        bus16.UP_ADR_IN = 22'h7_0000;
        bus16.UP_RD_IN  = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            bus16.UP_RD_IN = 1'b0;
        end
        bus16.DWN_VLD_IN[7] = 1'b1;
        bus16.DWN_DOUT_IN[7*32 +: 32] = 32'hCAFE_0007;
        @(negedge clk);
        bus16.DWN_VLD_IN[7] = 1'b0;
        n_run++; if (bus16.UP_VLD_OUT !== 1'b1 || bus16.UP_DOUT_OUT !== 32'hCAFE_0007) begin n_fail++; $display("FAIL vld_wins: got %b/%h want 1/cafe0007", bus16.UP_VLD_OUT, bus16.UP_DOUT_OUT); end
        n_run++; if (bus16.STA_TMO_OUT !== 1'b0 || bus16.STA_ERR_CNT_OUT !== 8'd0) begin n_fail++; $display("FAIL vld_wins_sta: got %b cnt %0d want 0 cnt 0", bus16.STA_TMO_OUT, bus16.STA_ERR_CNT_OUT); end
    endtask

    task automatic test_decode();
        @(negedge clk);
        bus11.UP_ADR_IN = 22'hC_0000;
        bus11.UP_RD_IN  = 1'b1;
        @(negedge clk);
        bus11.UP_RD_IN  = 1'b0;
        n_run++; if (bus11.UP_VLD_OUT !== 1'b1 || bus11.UP_DOUT_OUT !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL dec_rsp: got %b/%h want 1/deadbeef", bus11.UP_VLD_OUT, bus11.UP_DOUT_OUT); end
        n_run++; if (bus11.DWN_RD_OUT !== 11'h0) begin n_fail++; $display("FAIL dec_no_rd: got %h want 000", bus11.DWN_RD_OUT); end
        n_run++; if (bus11.STA_DEC_OUT !== 1'b1 || bus11.STA_ERR_CNT_OUT !== 8'd1) begin n_fail++; $display("FAIL dec_sta: got %b cnt %0d want 1 cnt 1", bus11.STA_DEC_OUT, bus11.STA_ERR_CNT_OUT); end
        clr_all();
        n_run++; if ({bus11.STA_TMO_OUT, bus11.STA_DEC_OUT, bus11.STA_PROT_OUT, bus11.STA_ERR_CNT_OUT} !== 11'h0) begin n_fail++; $display("FAIL dec_clr: got dec %b cnt %0d want 0 cnt 0", bus11.STA_DEC_OUT, bus11.STA_ERR_CNT_OUT); end
    endtask

    task automatic test_protocol();
        clr_all();
        @(negedge clk);
        bus16.UP_ADR_IN = 22'h2_0000;
        bus16.UP_RD_IN  = 1'b1;
        @(negedge clk);
        bus16.UP_RD_IN  = 1'b0;
        bus16.UP_ADR_IN = 22'h1_0000;
        bus16.UP_DIN_IN = 32'h1111_1111;
        bus16.UP_WR_IN  = 1'b1;
        @(negedge clk);
        bus16.UP_WR_IN  = 1'b0;
        bus16.UP_RD_IN  = 1'b1;
        n_run++; if (bus16.DWN_WR_OUT !== 16'h0) begin n_fail++; $display("FAIL prot_wr_drop: got %h want 0000", bus16.DWN_WR_OUT); end
        @(negedge clk);
        bus16.UP_RD_IN  = 1'b0;
        n_run++; if (bus16.DWN_RD_OUT !== 16'h0) begin n_fail++; $display("FAIL prot_rd_drop: got %h want 0000", bus16.DWN_RD_OUT); end
        bus16.DWN_VLD_IN[3] = 1'b1;
        bus16.DWN_DOUT_IN[3*32 +: 32] = 32'h3333_3333;
        @(negedge clk);
        bus16.DWN_VLD_IN[3] = 1'b0;
        n_run++; if (bus16.UP_VLD_OUT !== 1'b0) begin n_fail++; $display("FAIL prot_other_port: got vld %b want 0", bus16.UP_VLD_OUT); end
        bus16.DWN_VLD_IN[2] = 1'b1;
        bus16.DWN_DOUT_IN[2*32 +: 32] = 32'h2222_0002;
        @(negedge clk);
        bus16.DWN_VLD_IN[2] = 1'b0;
        n_run++; if (bus16.UP_VLD_OUT !== 1'b1 || bus16.UP_DOUT_OUT !== 32'h2222_0002) begin n_fail++; $display("FAIL prot_complete: got %b/%h want 1/22220002", bus16.UP_VLD_OUT, bus16.UP_DOUT_OUT); end
        n_run++; if (bus16.STA_PROT_OUT !== 1'b1 || bus16.STA_ERR_CNT_OUT !== 8'd2 || bus16.STA_TMO_OUT !== 1'b0) begin n_fail++; $display("FAIL prot_sta: got prot %b cnt %0d tmo %b want 1 2 0", bus16.STA_PROT_OUT, bus16.STA_ERR_CNT_OUT, bus16.STA_TMO_OUT); end
    endtask

    task automatic test_wr_rd_same();
        clr_all();
        @(negedge clk);
        bus16.UP_ADR_IN = 22'h4_0008;
        bus16.UP_DIN_IN = 32'h4444_0008;
        bus16.UP_WR_IN  = 1'b1;
        bus16.UP_RD_IN  = 1'b1;
        @(negedge clk);
        bus16.UP_WR_IN  = 1'b0;
        bus16.UP_RD_IN  = 1'b0;
        n_run++; if (bus16.DWN_WR_OUT !== 16'h0010 || bus16.DWN_RD_OUT !== 16'h0) begin n_fail++; $display("FAIL wr_prio: got wr %h rd %h want 0010/0000", bus16.DWN_WR_OUT, bus16.DWN_RD_OUT); end
        n_run++; if (bus16.STA_PROT_OUT !== 1'b1 || bus16.STA_ERR_CNT_OUT !== 8'd1) begin n_fail++; $display("FAIL wr_prio_sta: got %b cnt %0d want 1 cnt 1", bus16.STA_PROT_OUT, bus16.STA_ERR_CNT_OUT); end
        @(negedge clk);
        n_run++; if (bus16.UP_VLD_OUT !== 1'b0) begin n_fail++; $display("FAIL wr_prio_vld: got %b want 0", bus16.UP_VLD_OUT); end
    endtask

    task automatic test_saturate();
        clr_all();
        @(negedge clk);
        bus11.UP_ADR_IN = 22'hF_0000;
        bus11.UP_DIN_IN = 32'h5A5A_5A5A;
        bus11.UP_WR_IN  = 1'b1;
        repeat (254) @(negedge clk);
        bus11.UP_WR_IN  = 1'b0;
        @(negedge clk);
        n_run++; if (bus11.STA_ERR_CNT_OUT !== 8'd254) begin n_fail++; $display("FAIL sat_254: got %0d want 254", bus11.STA_ERR_CNT_OUT); end
        bus11.UP_WR_IN  = 1'b1;
        repeat (46) @(negedge clk);
        bus11.UP_WR_IN  = 1'b0;
        @(negedge clk);
        n_run++; if (bus11.STA_ERR_CNT_OUT !== 8'd255 || bus11.STA_DEC_OUT !== 1'b1) begin n_fail++; $display("FAIL sat_255: got cnt %0d dec %b want 255 1", bus11.STA_ERR_CNT_OUT, bus11.STA_DEC_OUT); end
        n_run++; if (bus11.DWN_WR_OUT !== 11'h0) begin n_fail++; $display("FAIL sat_drop: got %h want 000", bus11.DWN_WR_OUT); end
        bus11.STA_CLR_IN = 1'b1;
        bus11.UP_WR_IN   = 1'b1;
        @(negedge clk);
        bus11.STA_CLR_IN = 1'b0;
        bus11.UP_WR_IN   = 1'b0;
        n_run++; if (bus11.STA_ERR_CNT_OUT !== 8'd0 || bus11.STA_DEC_OUT !== 1'b0) begin n_fail++; $display("FAIL clr_prio: got cnt %0d dec %b want 0 0", bus11.STA_ERR_CNT_OUT, bus11.STA_DEC_OUT); end
    endtask

    task automatic test_reset_mid_read();
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        bus16.UP_ADR_IN = 22'h6_0000;
        bus16.UP_RD_IN  = 1'b1;
        @(negedge clk);
        bus16.UP_RD_IN  = 1'b0;
        n_run++; if (bus16.DWN_RD_OUT !== 16'h0040) begin n_fail++; $display("FAIL mid_rd_strobe: got %h want 0040", bus16.DWN_RD_OUT); end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_run++; if (bus16.DWN_RD_OUT !== 16'h0 || bus16.DWN_WR_OUT !== 16'h0 || bus16.DWN_ADR_OUT !== 16'h0 || bus16.DWN_DIN_OUT !== 32'h0) begin n_fail++; $display("FAIL async_dwn: got rd %h wr %h adr %h din %h want all 0", bus16.DWN_RD_OUT, bus16.DWN_WR_OUT, bus16.DWN_ADR_OUT, bus16.DWN_DIN_OUT); end
        n_run++; if (bus16.UP_VLD_OUT !== 1'b0 || bus16.UP_DOUT_OUT !== 32'h0) begin n_fail++; $display("FAIL async_up: got %b/%h want 0/0", bus16.UP_VLD_OUT, bus16.UP_DOUT_OUT); end
        n_run++; if (bus16.STA_PROT_OUT !== 1'b0 || bus16.STA_ERR_CNT_OUT !== 8'd0) begin n_fail++; $display("FAIL async_sta: got prot %b cnt %0d want 0 0", bus16.STA_PROT_OUT, bus16.STA_ERR_CNT_OUT); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus16.DWN_VLD_IN[6] = 1'b1;
        bus16.DWN_DOUT_IN[6*32 +: 32] = 32'h6666_6666;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 4) bus16.DWN_VLD_IN[6] = 1'b0;
            if (bus16.UP_VLD_OUT !== 1'b0) seen = 1'b1;
        end
        n_run++; if (seen) begin n_fail++; $display("FAIL rst_no_vld: got upstream vld after release want none"); end
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus16.UP_ADR_IN = '0; bus16.UP_WR_IN = 1'b0; bus16.UP_RD_IN = 1'b0; bus16.UP_DIN_IN = '0;
        bus16.DWN_DOUT_IN = '0; bus16.DWN_VLD_IN = '0; bus16.STA_CLR_IN = 1'b0;
        bus11.UP_ADR_IN = '0; bus11.UP_WR_IN = 1'b0; bus11.UP_RD_IN = 1'b0; bus11.UP_DIN_IN = '0;
        bus11.DWN_DOUT_IN = '0; bus11.DWN_VLD_IN = '0; bus11.STA_CLR_IN = 1'b0;

        test_reset();
        test_write();
        test_read_zero_wait();
        test_timeout();
        test_vld_at_tmo();
        test_decode();
        test_protocol();
        test_wr_rd_same();
        test_saturate();
        test_reset_mid_read();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
